data_mem_ctrl: RTL and testbench

Data-memory responder for the CPU datapath's load/store port. Accepts one load or store request at a time, stalls the core through `mem_busy` while the access is in flight, returns load data with a one-cycle `load_valid` strobe for register write-back, and commits stores to an internal 8-bit-wide RAM. It sits between the datapath's register read ports (address and store data) and its `ram_data` / `cpu_paused` inputs.

---
 rtl/data_mem_ctrl.sv | 155 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store responder for the CPU datapath with an internal
// 256 x 8 RAM. It serves one access at a time and stalls the core through
// mem_busy while the access is in flight.
// Optional feature macro: DMEM_WAIT_EN adds WAIT_CYCLES wait states to each
// access, which models slow external memory.
module data_mem_ctrl #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_load,
    input  logic       req_store,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       load_valid,
    output logic       store_done,
    output logic       mem_busy
);

`ifdef DMEM_WAIT_EN
    localparam int unsigned W_WAITS = WAIT_CYCLES;
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;
`else
    // WAIT_CYCLES has no effect unless wait states are compiled in.
    localparam int unsigned W_WAITS = WAIT_CYCLES * 0;
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
`endif

    state_t     r_state;
    state_t     w_next;
    logic       w_req;
    logic       r_is_store;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_rd;
    logic [7:0] r_hold;
    logic [7:0] r_mem [DEPTH];
`ifdef DMEM_WAIT_EN
    logic [3:0] r_wait_cnt;
`endif

    assign w_req = req_load | req_store;

    // Next-state logic and outputs; the stall is combinational in IDLE so the
    // requesting instruction stalls in its own cycle.
    always_comb begin
        w_next     = r_state;
        mem_busy   = 1'b0;
        load_valid = 1'b0;
        store_done = 1'b0;
        rdata      = r_hold;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_next = S_ACCESS;
                end
                mem_busy = w_req;
            end
            S_ACCESS: begin
                mem_busy = 1'b1;
                if (W_WAITS == 0) begin
                    w_next = S_DONE;
                end else begin
`ifdef DMEM_WAIT_EN
                    w_next = S_WAIT;
`else
                    w_next = S_DONE;
`endif
                end
            end
`ifdef DMEM_WAIT_EN
            S_WAIT: begin
                mem_busy = 1'b1;
                if (r_wait_cnt == '0) begin
                    w_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                // Requests seen here belong to the instruction that is still stalled.
                w_next = S_IDLE;
                if (r_is_store) begin
                    store_done = 1'b1;
                end else begin
                    load_valid = 1'b1;
                    rdata      = r_rd;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (!rst_n) begin
            mem_busy = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latch the request operands on acceptance; if both requests are high, the store wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_is_store <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else if (r_state == S_IDLE && w_req) begin
            r_is_store <= req_store;
            r_addr     <= addr;
            r_wdata    <= wdata;
        end
    end

    // Read register is filled in ACCESS; rdata keeps the last completed load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd   <= '0;
            r_hold <= '0;
        end else begin
            if (r_state == S_ACCESS && !r_is_store) begin
                r_rd <= r_mem[r_addr];
            end
            if (r_state == S_DONE && !r_is_store) begin
                r_hold <= r_rd;
            end
        end
    end

    // Store commit on the edge leaving ACCESS; reset on that edge suppresses it.
    always_ff @(posedge clk) begin
        if (rst_n && r_state == S_ACCESS && r_is_store) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

`ifdef DMEM_WAIT_EN
    // Wait-state down-counter, loaded with WAIT_CYCLES-1 on entry to WAIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_ACCESS && w_next == S_WAIT) begin
            r_wait_cnt <= 4'(W_WAITS - 1);
        end else if (r_state == S_WAIT && r_wait_cnt != '0) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed and random load/store traffic for data_mem_ctrl,
// checked against an array model of the RAM plus the last-load register.
module tb_data_mem_ctrl;

`ifdef DMEM_WAIT_EN
    localparam int unsigned WC    = 3;
    localparam int unsigned EXTRA = WC;
`else
    localparam int unsigned WC    = 2;
    localparam int unsigned EXTRA = 0;
`endif
    localparam int unsigned LAT = 2 + EXTRA;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_load;
    logic       req_store;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       load_valid;
    logic       store_done;
    logic       mem_busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] model_mem [256];
    logic [7:0] model_rdata;

    always #5 clk = ~clk;

    data_mem_ctrl #(
        .DEPTH       (256),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_load   (req_load),
        .req_store  (req_store),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .load_valid (load_valid),
        .store_done (store_done),
        .mem_busy   (mem_busy)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // One access from acceptance through DONE; the requester holds its request
    // until DONE, while addr/wdata are scrambled after acceptance.
    task automatic access(input bit ld, input bit st, input logic [7:0] a, input logic [7:0] d);
        bit         is_ld;
        logic [7:0] exp_rd;
        is_ld     = ld && !st;
        req_load  = ld;
        req_store = st;
        addr      = a;
        wdata     = d;
        for (int k = 0; k <= int'(LAT); k++) begin
            @(negedge clk);
            exp_rd = (k == int'(LAT) && is_ld) ? model_mem[a] : model_rdata;
            check("mem_busy",   {7'b0, mem_busy},   {7'b0, k < int'(LAT)});
            check("load_valid", {7'b0, load_valid}, {7'b0, (k == int'(LAT)) && is_ld});
            check("store_done", {7'b0, store_done}, {7'b0, (k == int'(LAT)) && st});
            check("rdata",      rdata,              exp_rd);
            @(posedge clk);
            #1;
            if (k == 0) begin
                addr  = 8'($urandom);
                wdata = 8'($urandom);
            end
        end
        req_load  = 1'b0;
        req_store = 1'b0;
        if (st) model_mem[a] = d;
        if (is_ld) model_rdata = model_mem[a];
    endtask

    task automatic idle_cycle();
        req_load  = 1'b0;
        req_store = 1'b0;
        @(negedge clk);
        check("idle_busy",  {7'b0, mem_busy},   8'h00);
        check("idle_lv",    {7'b0, load_valid}, 8'h00);
        check("idle_sd",    {7'b0, store_done}, 8'h00);
        check("idle_rdata", rdata,              model_rdata);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        req_load    = 1'b1;
        req_store   = 1'b0;
        addr        = 8'h3C;
        wdata       = 8'h00;
        model_rdata = 8'h00;

        // Reset held two cycles with a load request pending.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("rst_busy",  {7'b0, mem_busy},   8'h00);
            check("rst_rdata", rdata,              8'h00);
            check("rst_lv",    {7'b0, load_valid}, 8'h00);
            check("rst_sd",    {7'b0, store_done}, 8'h00);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("release_busy", {7'b0, mem_busy}, 8'h01);
        @(posedge clk);
        #1;
        // Abort that load with reset so the RAM is still untouched.
        rst_n    = 1'b0;
        req_load = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_busy",  {7'b0, mem_busy},   8'h00);
        check("abort_lv",    {7'b0, load_valid}, 8'h00);
        check("abort_rdata", rdata,              8'h00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle_cycle();

        // Fill the whole RAM with known random contents.
        for (int i = 0; i < 256; i++) begin
            access(1'b0, 1'b1, 8'(i), 8'($urandom));
        end

        // Store then load the same location.
        access(1'b0, 1'b1, 8'h3C, 8'hA5);
        access(1'b1, 1'b0, 8'h3C, 8'h00);
        check("load_3c", model_rdata, 8'hA5);

        // Boundary addresses.
        access(1'b0, 1'b1, 8'hFF, 8'h11);
        access(1'b0, 1'b1, 8'h00, 8'h22);
        access(1'b1, 1'b0, 8'hFF, 8'h00);
        access(1'b1, 1'b0, 8'h00, 8'h00);

        // Simultaneous requests: the store wins.
        access(1'b1, 1'b1, 8'h10, 8'h7E);
        access(1'b1, 1'b0, 8'h10, 8'h00);

        // Reset during store ACCESS suppresses the commit.
        access(1'b0, 1'b1, 8'h20, 8'h99);
        req_store = 1'b1;
        addr      = 8'h20;
        wdata     = 8'h55;
        @(negedge clk);
        check("rs_busy_t", {7'b0, mem_busy}, 8'h01);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("rs_busy_forced", {7'b0, mem_busy},   8'h00);
        check("rs_sd_access",   {7'b0, store_done}, 8'h00);
        @(posedge clk);
        #1;
        req_store = 1'b0;
        @(negedge clk);
        check("rs_sd_after",  {7'b0, store_done}, 8'h00);
        check("rs_busy_after", {7'b0, mem_busy},  8'h00);
        check("rs_rdata",     rdata,              8'h00);
        rst_n       = 1'b1;
        model_rdata = 8'h00;
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, 8'h20, 8'h00);

        // Random traffic.
        for (int i = 0; i < 150; i++) begin
            int op;
            op = int'($urandom_range(3, 0));
            if (op == 3) begin
                idle_cycle();
            end else begin
                access(op != 1, op != 0, 8'($urandom), 8'($urandom));
            end
        end
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
